// File: rtl/float_sort_pkg.sv
// float_sort_pkg: shared types for the float sorter front end.
// FLEN is fixed at 64 for the FP64 datapath.
package float_sort_pkg;

    localparam int FLEN = 64;

    localparam logic [63:0] FP64_POS_INF = 64'h7FF0_0000_0000_0000;

    typedef logic [0:2][FLEN-1:0] float_triple_t;

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } collector_state_e;

endpackage

// File: rtl/float_triple_buf.sv
// float_triple_buf: one triple of float slots with fill count and pad mask.
// FILL accepts words into slot[count]; a closing word (last or slot 2) moves to ISSUE.
module float_triple_buf
    import float_sort_pkg::*;
#(
    parameter logic [FLEN-1:0] PAD_VALUE = FP64_POS_INF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_last,
    input  logic [FLEN-1:0]  i_data,
    input  logic             i_clear,
    output collector_state_e o_state,
    output float_triple_t    o_slots,
    output logic [2:0]       o_pad_mask
);

    collector_state_e r_state;
    float_triple_t    r_slots;
    logic [1:0]       r_count;
    logic [2:0]       r_pad_mask;
    logic             w_close;

    assign w_close = i_last || (r_count == 2'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FILL;
            r_slots    <= '0;
            r_count    <= '0;
            r_pad_mask <= '0;
        end else if (i_clear && r_state == ISSUE) begin
            r_state    <= FILL;
            r_count    <= '0;
            r_pad_mask <= '0;
        end else if (i_load && r_state == FILL) begin
            for (int k = 0; k < 3; k++) begin
                if (r_count == 2'(k)) begin
                    r_slots[k] <= i_data;
                end else if (i_last && r_count < 2'(k)) begin
                    // Padding with +inf keeps the filler at the tail after sorting
                    r_slots[k]    <= PAD_VALUE;
                    r_pad_mask[k] <= 1'b1;
                end
            end
            if (w_close) begin
                r_state <= ISSUE;
            end else begin
                r_count <= r_count + 2'd1;
            end
        end
    end

    assign o_state    = r_state;
    assign o_slots    = r_slots;
    assign o_pad_mask = r_pad_mask;

endmodule

// File: rtl/float_triple_collector.sv
// float_triple_collector: packs a float stream into triples and issues them to the sorter.
// FLOAT_COLLECTOR_DOUBLE_BUF_EN selects ping-pong buffering instead of a single buffer.
module float_triple_collector
    import float_sort_pkg::*;
#(
    parameter logic [FLEN-1:0] PAD_VALUE = FP64_POS_INF,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FLEN-1:0]  in_data,
    input  logic             in_last,
    output logic             sort_valid_in,
    output float_triple_t    sort_unsorted,
    input  logic             sort_busy,
    output logic [2:0]       pad_mask,
    output logic [CNT_W-1:0] issued_cnt
);

    logic             w_accept;
    logic             w_issue;
    logic             r_guard;
    logic [CNT_W-1:0] r_issued_cnt;

    assign w_accept = in_valid && in_ready;

`ifdef FLOAT_COLLECTOR_DOUBLE_BUF_EN
    collector_state_e w_state [2];
    float_triple_t    w_slots [2];
    logic [2:0]       w_pad   [2];
    logic             r_rd;
    logic             w_wr;

    // Fill target is the read buffer until it is complete, then the other one
    assign w_wr = r_rd ^ (w_state[r_rd] == ISSUE);

    for (genvar g = 0; g < 2; g++) begin : g_buf
        float_triple_buf #(
            .PAD_VALUE (PAD_VALUE)
        ) u_buf (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_accept && (w_wr == 1'(g))),
            .i_last     (in_last),
            .i_data     (in_data),
            .i_clear    (w_issue && (r_rd == 1'(g))),
            .o_state    (w_state[g]),
            .o_slots    (w_slots[g]),
            .o_pad_mask (w_pad[g])
        );
    end

    assign in_ready      = (w_state[w_wr] == FILL);
    assign w_issue       = (w_state[r_rd] == ISSUE) && !sort_busy && !r_guard;
    assign sort_unsorted = w_slots[r_rd];
    assign pad_mask      = w_pad[r_rd];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd <= 1'b0;
        end else if (w_issue) begin
            r_rd <= ~r_rd;
        end
    end
`else
    collector_state_e w_state;

    float_triple_buf #(
        .PAD_VALUE (PAD_VALUE)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_last     (in_last),
        .i_data     (in_data),
        .i_clear    (w_issue),
        .o_state    (w_state),
        .o_slots    (sort_unsorted),
        .o_pad_mask (pad_mask)
    );

    assign in_ready = (w_state == FILL);
    assign w_issue  = (w_state == ISSUE) && !sort_busy && !r_guard;
`endif

    // guard masks the cycle before the sorter's busy flag rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_guard      <= 1'b0;
            r_issued_cnt <= '0;
        end else begin
            r_guard <= w_issue;
            if (w_issue) begin
                r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            end
        end
    end

    assign sort_valid_in = w_issue;
    assign issued_cnt    = r_issued_cnt;

endmodule

// File: tb/tb_float_triple_collector.sv
// tb_float_triple_collector: randomized scoreboard bench for the float triple collector.
// A queue model forms padded triples from accepted words; a monitor checks each issue pulse.
module tb_float_triple_collector;
    import float_sort_pkg::*;

    typedef struct packed {
        float_triple_t d;
        logic [2:0]    m;
    } exp_t;

`ifdef FLOAT_COLLECTOR_DOUBLE_BUF_EN
    localparam logic RDY_WHILE_BUSY = 1'b1;
`else
    localparam logic RDY_WHILE_BUSY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            sort_busy = 1'b0;
    logic [FLEN-1:0] in_data = '0;
    logic            in_ready;
    logic            sort_valid_in;
    float_triple_t   sort_unsorted;
    logic [2:0]      pad_mask;
    logic [15:0]     issued_cnt;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [FLEN-1:0] cur[$];
    int model_triples = 0;
    int n_popped = 0;
    int cyc = 0;
    int last_pulse = -100;
    bit busy_auto = 0;
    bit busy_force = 0;
    bit bp = 0;
    int bcnt = 0;

    always #5 clk = ~clk;

    float_triple_collector #(
        .PAD_VALUE (FP64_POS_INF),
        .CNT_W     (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .sort_valid_in (sort_valid_in),
        .sort_unsorted (sort_unsorted),
        .sort_busy     (sort_busy),
        .pad_mask      (pad_mask),
        .issued_cnt    (issued_cnt)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: accepted words queue up; a triple closes at 3 words or on last
    task automatic model_accept(input logic [FLEN-1:0] d, input logic last);
        exp_t e;
        cur.push_back(d);
        if (last || cur.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                if (k < cur.size()) begin
                    e.d[k] = cur[k];
                    e.m[k] = 1'b0;
                end else begin
                    e.d[k] = FP64_POS_INF;
                    e.m[k] = 1'b1;
                end
            end
            exp_q.push_back(e);
            cur.delete();
            model_triples++;
        end
    endtask

    function automatic logic [FLEN-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Sorter stand-in: busy for 3 cycles after each pulse, or forced
    always begin
        @(negedge clk);
        bp = rst && sort_valid_in;
        @(posedge clk);
        #1;
        if (busy_auto) begin
            if (bp) bcnt = 3;
            sort_busy = (bcnt > 0);
            if (bcnt > 0) bcnt--;
        end else begin
            sort_busy = busy_force;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst && sort_valid_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse, required none");
            end else begin
                e = exp_q.pop_front();
                for (int k = 0; k < 3; k++)
                    check($sformatf("slot%0d", k), sort_unsorted[k], e.d[k]);
                check("pad_mask", 64'(pad_mask), 64'(e.m));
                check("issued_cnt_at_pulse", 64'(issued_cnt), 64'(16'(n_popped)));
                n_popped++;
            end
            check("pulse_spacing", 64'(cyc - last_pulse >= 2), 64'd1);
            last_pulse = cyc;
        end
    end

    task automatic push_word(input logic [FLEN-1:0] d, input logic last);
        int n = 0;
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, last);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 300) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: got in_ready=0 for %0d cycles, required accept", n);
                done = 1;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int target;
        int n_acc;
        logic [FLEN-1:0] d;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(sort_valid_in), 64'd0);
        check("rst_pad_mask", 64'(pad_mask), 64'd0);
        check("rst_issued_cnt", 64'(issued_cnt), 64'd0);
        check("rst_unsorted0", sort_unsorted[0], 64'd0);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        push_word(64'h4008_0000_0000_0000, 1'b0);
        push_word(64'h3FF0_0000_0000_0000, 1'b0);
        push_word(64'h4000_0000_0000_0000, 1'b0);
        idle();
        drain();
        check("cnt_after_t1", 64'(issued_cnt), 64'd1);

        push_word(64'h4014_0000_0000_0000, 1'b1);
        idle();
        drain();
        push_word(64'h4014_0000_0000_0000, 1'b0);
        push_word(64'h4018_0000_0000_0000, 1'b1);
        idle();
        drain();

        busy_force = 1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) push_word(rnd64(), 1'b0);
        idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("busy_no_pulse", 64'(sort_valid_in), 64'd0);
            check("busy_in_ready", 64'(in_ready), 64'(RDY_WHILE_BUSY));
        end
        busy_force = 0;
        @(posedge clk);
        #2;
        @(negedge clk);
        check("pulse_after_busy", 64'(sort_valid_in), 64'd1);
        drain();

        busy_auto = 1;
        target = model_triples + 100;
        while (model_triples < target)
            push_word(rnd64(), ($urandom_range(0, 3) == 0));
        idle();
        drain();
        check("cnt_after_stream", 64'(issued_cnt), 64'(16'(model_triples)));
        busy_auto = 0;

`ifdef FLOAT_COLLECTOR_DOUBLE_BUF_EN
        busy_force = 1;
        @(posedge clk);
        #2;
        n_acc = 0;
        d = rnd64();
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_data = d;
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, 1'b0);
                n_acc++;
                d = rnd64();
            end
            @(posedge clk);
            #1;
        end
        check("dbuf_accepted", 64'(n_acc), 64'd6);
        check("dbuf_stall", 64'(in_ready), 64'd0);
        idle();
        busy_force = 0;
        busy_auto  = 1;
        drain();
        busy_auto = 0;
`endif

        busy_force = 1;
        @(posedge clk);
        #2;
        push_word(rnd64(), 1'b0);
        push_word(rnd64(), 1'b1);
        idle();
        @(negedge clk);
        check("held_pad_mask", 64'(pad_mask), 64'd4);
        check("held_no_pulse", 64'(sort_valid_in), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_valid", 64'(sort_valid_in), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_pad_mask", 64'(pad_mask), 64'd0);
        check("midrst_issued_cnt", 64'(issued_cnt), 64'd0);
        check("midrst_unsorted0", sort_unsorted[0], 64'd0);
        exp_q.delete();
        cur.delete();
        n_popped = 0;
        model_triples = 0;
        last_pulse = -100;
        busy_force = 0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_word(rnd64(), 1'b0);
        idle();
        drain();
        check("cnt_after_reset", 64'(issued_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
